// File: rtl/roi_apb_multi.sv
// roi_apb_multi: APB slave holding NUM_ROI shadow rectangles, committed atomically to the active
// outputs on the first frame_start_i after software arms COMMIT. Define ROI_CLAMP_EN to clamp at commit.
module roi_apb_multi #(
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int COORD_WIDTH    = 10,
  parameter int NUM_ROI        = 4,
  parameter int FRAME_W        = 1024,
  parameter int FRAME_H        = 768
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      apb_psel_i,
  input  logic                      apb_penable_i,
  input  logic                      apb_pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0] apb_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0] apb_pwdata_i,
  output logic [APB_DATA_WIDTH-1:0] apb_prdata_o,
  output logic                      apb_pready_o,
  output logic                      apb_pslverr_o,
  input  logic                      frame_start_i,
  output logic [NUM_ROI*32-1:0]     roi_xy0_o,
  output logic [NUM_ROI*32-1:0]     roi_xy1_o,
  output logic [NUM_ROI-1:0]        roi_valid_o,
  output logic                      commit_done_o
);

  localparam logic [4:0] NUM_ROI_L = 5'(NUM_ROI);
  localparam int         HI_W      = APB_ADDR_WIDTH - 8;

  if (APB_DATA_WIDTH != 32 || APB_ADDR_WIDTH < 9 || COORD_WIDTH < 1 || COORD_WIDTH > 16 ||
      NUM_ROI < 1 || NUM_ROI > 16 || FRAME_W < 1 || FRAME_H < 1) begin : g_param_check
    $error("roi_apb_multi: parameter out of legal range");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  apb_state_e                       state_reg;
  logic                             pready_reg;
  logic                             pslverr_reg;
  logic [APB_DATA_WIDTH-1:0]        prdata_reg;

  logic [COORD_WIDTH-1:0]           sx0_reg [NUM_ROI];
  logic [COORD_WIDTH-1:0]           sy0_reg [NUM_ROI];
  logic [COORD_WIDTH-1:0]           sx1_reg [NUM_ROI];
  logic [COORD_WIDTH-1:0]           sy1_reg [NUM_ROI];
  logic [NUM_ROI-1:0]               en_reg;

  logic [COORD_WIDTH-1:0]           ax0_reg [NUM_ROI];
  logic [COORD_WIDTH-1:0]           ay0_reg [NUM_ROI];
  logic [COORD_WIDTH-1:0]           ax1_reg [NUM_ROI];
  logic [COORD_WIDTH-1:0]           ay1_reg [NUM_ROI];
  logic [NUM_ROI-1:0]               valid_reg;
  logic [NUM_ROI-1:0]               errmask_reg;
  logic                             pending_reg;
  logic                             err_reg;
  logic                             commit_done_reg;

  logic [COORD_WIDTH-1:0]           cx0 [NUM_ROI];
  logic [COORD_WIDTH-1:0]           cy0 [NUM_ROI];
  logic [COORD_WIDTH-1:0]           cx1 [NUM_ROI];
  logic [COORD_WIDTH-1:0]           cy1 [NUM_ROI];
  logic [NUM_ROI-1:0]               coord_ok;
  logic [NUM_ROI-1:0]               commit_err;

  logic [HI_W-1:0]                  addr_hi;
  logic [3:0]                       roi_sel;
  logic [1:0]                       reg_sel;
  logic                             roi_hit;
  logic                             glb_hit;
  logic                             wr_fire;
  logic                             commit_fire;
  logic                             commit_wr;
  logic                             err_w1c;
  logic [31:0]                      rd_data;
  logic                             unused_wdata;

  function automatic logic [31:0] pack_xy(input logic [COORD_WIDTH-1:0] x,
                                          input logic [COORD_WIDTH-1:0] y);
    logic [31:0] w;
    w = '0;
    w[COORD_WIDTH-1:0]     = x;
    w[16 +: COORD_WIDTH]   = y;
    return w;
  endfunction

`ifdef ROI_CLAMP_EN
  function automatic logic [COORD_WIDTH-1:0] clamp_coord(input logic [COORD_WIDTH-1:0] v,
                                                         input int unsigned lim);
    logic [31:0] v_ext;
    v_ext = 32'(v);
    if (v_ext > lim) return lim[COORD_WIDTH-1:0];
    return v;
  endfunction
`endif

  // Address decode: ROI k at 0x10*k + {0,4,8}, globals at 0x100..0x108, word aligned only.
  assign addr_hi = apb_paddr_i[APB_ADDR_WIDTH-1:8];
  assign roi_sel = apb_paddr_i[7:4];
  assign reg_sel = apb_paddr_i[3:2];
  assign roi_hit = (addr_hi == '0) && ({1'b0, roi_sel} < NUM_ROI_L) &&
                   (apb_paddr_i[1:0] == 2'b00) && (reg_sel != 2'd3);
  assign glb_hit = (addr_hi == HI_W'(1)) && (roi_sel == 4'd0) &&
                   (apb_paddr_i[1:0] == 2'b00) && (reg_sel != 2'd3);

  assign wr_fire     = (state_reg == ACCESS) && apb_psel_i && apb_penable_i && apb_pwrite_i;
  assign commit_fire = frame_start_i && pending_reg;
  assign commit_wr   = wr_fire && glb_hit && (reg_sel == 2'd0) && apb_pwdata_i[0];
  assign err_w1c     = wr_fire && glb_hit && (reg_sel == 2'd1) && apb_pwdata_i[1];
  assign unused_wdata = ^apb_pwdata_i;

  always_comb begin
    coord_ok   = '0;
    commit_err = '0;
    for (int k = 0; k < NUM_ROI; k++) begin
`ifdef ROI_CLAMP_EN
      cx0[k] = clamp_coord(sx0_reg[k], FRAME_W - 1);
      cx1[k] = clamp_coord(sx1_reg[k], FRAME_W - 1);
      cy0[k] = clamp_coord(sy0_reg[k], FRAME_H - 1);
      cy1[k] = clamp_coord(sy1_reg[k], FRAME_H - 1);
`else
      cx0[k] = sx0_reg[k];
      cx1[k] = sx1_reg[k];
      cy0[k] = sy0_reg[k];
      cy1[k] = sy1_reg[k];
`endif
      coord_ok[k]   = (cx0[k] <= cx1[k]) && (cy0[k] <= cy1[k]);
      commit_err[k] = en_reg[k] && !coord_ok[k];
    end
  end

  always_comb begin
    rd_data = '0;
    if (roi_hit) begin
      for (int k = 0; k < NUM_ROI; k++) begin
        if (roi_sel == 4'(k)) begin
          case (reg_sel)
            2'd0:    rd_data = pack_xy(sx0_reg[k], sy0_reg[k]);
            2'd1:    rd_data = pack_xy(sx1_reg[k], sy1_reg[k]);
            2'd2:    rd_data = {31'b0, en_reg[k]};
            default: rd_data = '0;
          endcase
        end
      end
    end else if (glb_hit) begin
      case (reg_sel)
        2'd1:    rd_data = {30'b0, err_reg, pending_reg};
        2'd2:    rd_data[NUM_ROI-1:0] = errmask_reg;
        default: rd_data = '0;
      endcase
    end
  end

  // Response is registered on entry to ACCESS so pready/prdata/pslverr are valid only there.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_reg   <= IDLE;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      prdata_reg  <= '0;
    end else begin
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      prdata_reg  <= '0;
      case (state_reg)
        IDLE: begin
          if (apb_psel_i && !apb_penable_i) state_reg <= SETUP;
        end
        SETUP: begin
          if (!apb_psel_i) begin
            state_reg <= IDLE;
          end else if (apb_penable_i) begin
            state_reg   <= ACCESS;
            pready_reg  <= 1'b1;
            pslverr_reg <= !(roi_hit || glb_hit);
            prdata_reg  <= apb_pwrite_i ? '0 : rd_data;
          end
        end
        ACCESS: begin
          state_reg <= (apb_psel_i && !apb_penable_i) ? SETUP : IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Commit samples the pre-write shadow; a COMMIT write in the same cycle re-arms afterwards.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      for (int k = 0; k < NUM_ROI; k++) begin
        sx0_reg[k] <= '0;
        sy0_reg[k] <= '0;
        sx1_reg[k] <= '0;
        sy1_reg[k] <= '0;
        ax0_reg[k] <= '0;
        ay0_reg[k] <= '0;
        ax1_reg[k] <= '0;
        ay1_reg[k] <= '0;
      end
      en_reg          <= '0;
      valid_reg       <= '0;
      errmask_reg     <= '0;
      pending_reg     <= 1'b0;
      err_reg         <= 1'b0;
      commit_done_reg <= 1'b0;
    end else begin
      commit_done_reg <= commit_fire;
      pending_reg     <= commit_wr || (pending_reg && !commit_fire);
      err_reg         <= (err_reg && !err_w1c) || (commit_fire && (|commit_err));
      if (commit_fire) begin
        for (int k = 0; k < NUM_ROI; k++) begin
          ax0_reg[k] <= cx0[k];
          ay0_reg[k] <= cy0[k];
          ax1_reg[k] <= cx1[k];
          ay1_reg[k] <= cy1[k];
        end
        valid_reg   <= en_reg & coord_ok;
        errmask_reg <= commit_err;
      end
      if (wr_fire && roi_hit) begin
        for (int k = 0; k < NUM_ROI; k++) begin
          if (roi_sel == 4'(k)) begin
            case (reg_sel)
              2'd0: begin
                sx0_reg[k] <= apb_pwdata_i[COORD_WIDTH-1:0];
                sy0_reg[k] <= apb_pwdata_i[16 +: COORD_WIDTH];
              end
              2'd1: begin
                sx1_reg[k] <= apb_pwdata_i[COORD_WIDTH-1:0];
                sy1_reg[k] <= apb_pwdata_i[16 +: COORD_WIDTH];
              end
              2'd2:    en_reg[k] <= apb_pwdata_i[0];
              default: ;
            endcase
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_ROI; gi++) begin : g_roi_out
    assign roi_xy0_o[gi*32 +: 32] = pack_xy(ax0_reg[gi], ay0_reg[gi]);
    assign roi_xy1_o[gi*32 +: 32] = pack_xy(ax1_reg[gi], ay1_reg[gi]);
  end

  assign roi_valid_o   = valid_reg;
  assign commit_done_o = commit_done_reg;
  assign apb_prdata_o  = prdata_reg;
  assign apb_pready_o  = pready_reg;
  assign apb_pslverr_o = pslverr_reg;

endmodule
